pit_irq_arbiter: RTL
====================

# pit_irq_arbiter

Interrupt arbiter and claim/complete controller sitting between several `minipit` timer instances and the single interrupt output pin of the chip top. It captures rising edges of each timer's `interrupting` pulse into pending bits and masks them. It picks one pending source by round-robin and presents it with an ID to the consumer, which may be external logic on `uo_out` or a future JTAG-visible register. It then sequences the claim/complete handshake so each timer event is serviced exactly once.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources (2..8).
- `ID_W`, 2: width of source ID; must equal clog2(`N_SRC`).

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, synchronous and active-low.
- `src_irq`  in  `N_SRC`  per-source interrupt pulses from the `minipit` instances (level; only rising edges count).
- `mask`  in  `N_SRC`  per-source enable; 1 = eligible for arbitration.
- `claim`  in  1  consumer accepts the offered interrupt (single-cycle pulse).
- `complete`  in  1  consumer finished servicing (single-cycle pulse).
- `irq_out`  out  1  high while an interrupt is offered.
- `irq_id`  out  `ID_W`  source ID of the offered or in-service interrupt.
- `pending`  out  `N_SRC`  captured, not-yet-claimed events.
- `busy`  out  1  state != IDLE.
- `lost_sel`  in  `ID_W`  source selecting `lost_cnt` (present only with the macro).
- `lost_cnt`  out  4  lost-event count of source `lost_sel` (present only with the macro).

## Operation
- Edge detect: `src_q` registers `src_irq`; rise[i] = `src_irq[i]` & ~`src_q[i]`. Rise sets `pending[i]` regardless of `mask`.
- Rise on a source whose `pending` bit is already 1 is a lost event. The bit stays 1.
- FSM states:
  - IDLE: if (`pending` & `mask`) != 0, pick a winner by round-robin, go to OFFER, latch `irq_id` = winner.
  - OFFER: `irq_out` = 1. Outcomes:
    - `claim` → clear `pending[irq_id]`, go to SERVICE.
    - Else if `mask[irq_id]` = 0 → go to IDLE (withdrawn; pending retained).
  - SERVICE: `irq_out` = 0, `irq_id` held. On `complete` → `last` = `irq_id`, go to IDLE.
- Round-robin: search starts at `last`+1 mod `N_SRC` and wraps; the first set bit of `pending` & `mask` wins.
- `claim` outside OFFER is ignored. `complete` outside SERVICE is ignored.
- If a rise and the claim-clear hit the same source in the same cycle, the set wins: `pending` stays 1 and this does not count as lost.
- A rise on the in-service source during SERVICE sets `pending` normally; that source is re-offered after `complete` only if the round-robin order reaches it.

## Timing
- Reset values (synchronous, `rst_n` = 0 at a rising edge): state IDLE, `irq_out` 0, `irq_id` 0, `pending` 0, `src_q` 0, `busy` 0, `last` = `N_SRC`-1 (source 0 first), lost counters 0.
- Reset mid-operation discards the offer, the in-service ID and all pending events.
- Latency from source to offer:
  - `src_irq[i]` first sampled high at edge k → `pending[i]` = 1 after k.
  - `irq_out` = 1 after k+1, if IDLE and unmasked.
- `claim` sampled at edge m in OFFER → `irq_out` = 0 and `pending[irq_id]` = 0 after m.
- `complete` at edge n → IDLE after n; the earliest next `irq_out` is after n+1.
- All outputs are registered except `pending`, `busy` and `lost_cnt`, which are direct register reads.

## Configuration
- `PIT_IRQ_LOST_CNT_EN`:
  - Defined: one 4-bit saturating lost-event counter per source, which holds at 15.
  - Defined: `lost_sel`/`lost_cnt` ports exist; `lost_cnt` is the combinational read of counter[`lost_sel`].
  - Undefined: counters and both ports are absent.
  - Arbitration is identical in both builds.

## Structure
- Package `pit_irq_pkg`:
  - FSM state enum (IDLE, OFFER, SERVICE).
  - Lost-counter width (4) and saturation value (15).
- Sub-module `pit_rr_picker`: combinational; inputs request vector and `last`; outputs `found` and `winner` ID. Parameterised by `N_SRC`/`ID_W`.
- The top holds the edge detect, pending, FSM and the optional counters.

## Test plan
- Single event: pulse `src_irq[2]` one cycle, `mask`=4'hF → `irq_out` high 2 cycles later with `irq_id`=2. `claim` → `pending`=0. `complete` → `busy`=0.
- Round-robin: `src_irq`=4'hF simultaneously, then claim/complete each offer → order of IDs is 0,1,2,3. Re-fire all → order is 0,1,2,3 again, since `last`=3 wraps to 0.
- Mask withdrawal: offer ID 1, then clear `mask[1]` before `claim` → `irq_out` drops next cycle, `pending[1]` stays 1. Re-enable → re-offered.
- Simultaneous set and clear: rise on `src_irq[0]` in the same cycle as `claim` of ID 0 → `pending[0]`=1 afterwards and the source is re-offered after `complete`.
- Lost events (macro defined): hold `mask`=0, give 20 rising edges on `src_irq[3]`, set `lost_sel`=3 → `lost_cnt`=15. Assert `rst_n`=0 for one edge → `lost_cnt`=0.
- Stray handshakes: `complete` in IDLE and `claim` in SERVICE → no state change, `pending` unchanged.

Source files
------------

// File: rtl/pit_irq_pkg.sv
// Shared types and constants for the timer interrupt arbiter.
// Contents:
//   state_e    - arbiter FSM states (idle, offering, in service)
//   LostCntW   - width of each per-source lost-event counter
//   LostCntMax - saturation value of the lost-event counters
package pit_irq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StService
    } state_e;

    localparam int unsigned LostCntW = 4;
    localparam logic [LostCntW-1:0] LostCntMax = 4'd15;

endpackage

// File: rtl/pit_rr_picker.sv
// Combinational round-robin picker.
// Search starts one past the previous winner and wraps; the first set request wins.
// Ports:
//   req_i    - request vector (pending & mask)
//   last_i   - ID of the previously completed source
//   found_o  - at least one request is set
//   winner_o - ID of the selected request (0 when none)
module pit_rr_picker #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic             found_o,
    output logic [ID_W-1:0]  winner_o
);

    int unsigned idx;

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int unsigned off = 1; off <= N_SRC; off++) begin
            idx = (32'(last_i) + off) % N_SRC;
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pit_irq_arbiter.sv
// Interrupt arbiter and claim/complete controller for several minipit timers.
// Rising edges of each source set a pending bit; one masked-in pending source is
// offered at a time (round-robin) and sequenced through claim and complete.
// Optional feature macro: PIT_IRQ_LOST_CNT_EN adds per-source saturating
// lost-event counters and the lost_sel_i/lost_cnt_o read port.
// Ports:
//   clk_i       - clock
//   rst_ni      - synchronous active-low reset
//   src_irq_i   - per-source interrupt levels (rising edges count)
//   mask_i      - per-source arbitration enable
//   claim_i     - consumer accepts the offered interrupt
//   complete_i  - consumer finished servicing
//   irq_out_o   - an interrupt is being offered
//   irq_id_o    - ID of the offered or in-service source
//   pending_o   - captured, not-yet-claimed events
//   busy_o      - arbiter is not idle
//   lost_sel_i  - lost-counter select (macro only)
//   lost_cnt_o  - lost-event count of the selected source (macro only)
module pit_irq_arbiter
    import pit_irq_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SRC-1:0]    src_irq_i,
    input  logic [N_SRC-1:0]    mask_i,
    input  logic                claim_i,
    input  logic                complete_i,
    output logic                irq_out_o,
    output logic [ID_W-1:0]     irq_id_o,
    output logic [N_SRC-1:0]    pending_o,
    output logic                busy_o
`ifdef PIT_IRQ_LOST_CNT_EN
    ,
    input  logic [ID_W-1:0]     lost_sel_i,
    output logic [LostCntW-1:0] lost_cnt_o
`endif
);

    state_e           state_q, state_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic             irq_out_q, irq_out_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_clr;
    logic             found;
    logic [ID_W-1:0]  winner;

    pit_rr_picker #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_picker (
        .req_i    (pending_q & mask_i),
        .last_i   (last_q),
        .found_o  (found),
        .winner_o (winner)
    );

    always_comb begin
        state_d   = state_q;
        irq_out_d = irq_out_q;
        irq_id_d  = irq_id_q;
        last_d    = last_q;
        pend_clr  = '0;
        rise      = src_irq_i & ~src_q;

        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d   = StOffer;
                    irq_out_d = 1'b1;
                    irq_id_d  = winner;
                end
            end
            StOffer: begin
                if (claim_i) begin
                    pend_clr[irq_id_q] = 1'b1;
                    state_d            = StService;
                    irq_out_d          = 1'b0;
                end else if (!mask_i[irq_id_q]) begin
                    // Withdrawn: the event stays pending for a later offer.
                    state_d   = StIdle;
                    irq_out_d = 1'b0;
                end
            end
            StService: begin
                if (complete_i) begin
                    last_d  = irq_id_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                irq_out_d = 1'b0;
            end
        endcase

        // A new edge beats a same-cycle claim clear.
        pending_d = (pending_q & ~pend_clr) | rise;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            src_q     <= '0;
            pending_q <= '0;
            irq_out_q <= 1'b0;
            irq_id_q  <= '0;
            last_q    <= ID_W'(N_SRC - 1);
        end else begin
            state_q   <= state_d;
            src_q     <= src_irq_i;
            pending_q <= pending_d;
            irq_out_q <= irq_out_d;
            irq_id_q  <= irq_id_d;
            last_q    <= last_d;
        end
    end

    assign irq_out_o = irq_out_q;
    assign irq_id_o  = irq_id_q;
    assign pending_o = pending_q;
    assign busy_o    = (state_q != StIdle);

`ifdef PIT_IRQ_LOST_CNT_EN
    logic [LostCntW-1:0] lost_q [N_SRC];
    logic [LostCntW-1:0] lost_d [N_SRC];

    // Lost = edge on an already-pending source that is not being claimed this cycle.
    always_comb begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            lost_d[i] = lost_q[i];
            if (rise[i] && pending_q[i] && !pend_clr[i] && (lost_q[i] != LostCntMax)) begin
                lost_d[i] = lost_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                lost_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                lost_q[i] <= lost_d[i];
            end
        end
    end

    assign lost_cnt_o = lost_q[lost_sel_i];
`else
    // No lost-event counters in this build.
`endif

endmodule
